kuznechik_enc_iter: RTL and testbench

- Iterative GOST R 34.12-2015 (Kuznechik) block encryptor; the counterpart of the team's KuznechikDecoderInst decryption path.
- Accepts a 128-bit plaintext and a 256-bit key over a valid/ready handshake.
- Expands round keys on-chip, runs 9 LSX rounds plus a final X at one round per cycle, and returns the ciphertext over a valid/ready handshake.
- Sits in front of the decoder in the kuznechik_inst examples, so encrypt/decrypt round trips can be checked in one bench.

---
 rtl/kuznechik_enc_iter.sv | 189 ++++++++++++++++++
 tb/tb_kuznechik_enc_iter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kuznechik_enc_iter.sv
// Iterative Kuznechik (GOST R 34.12-2015) block encryptor: on-chip key expansion
// (32 Feistel steps) followed by 9 LSX rounds and a final X, one step per clock.
module kuznechik_enc_iter #(
    parameter int CACHE_KEY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block,
    input  logic [255:0] key,
    output logic [127:0] encoded,
    output logic         out_valid,
    input  logic         out_ready
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and encoded is held
    // constant for as long as out_valid stays high.

    localparam logic [7:0] PI [0:255] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Linear-map coefficients indexed by byte position j (byte j = bits [8j+7:8j]).
    localparam logic [7:0] LC [0:15] = '{
        8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
        8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
    };

    // GF(2^8) multiply modulo x^8+x^7+x^6+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

    function automatic logic [127:0] lin_l(input logic [127:0] v);
        logic [127:0] a;
        logic [7:0]   t;
        a = v;
        for (int r = 0; r < 16; r++) begin
            t = '0;
            for (int j = 0; j < 16; j++) t = t ^ gf_mul(a[8*j +: 8], LC[j]);
            a = {t, a[127:8]};
        end
        return a;
    endfunction

    function automatic logic [127:0] sub_s(input logic [127:0] v);
        logic [127:0] a;
        a = '0;
        for (int j = 0; j < 16; j++) a[8*j +: 8] = PI[v[8*j +: 8]];
        return a;
    endfunction

    typedef enum logic [1:0] {IDLE, KEYEXP, ENC, DONE} state_t;

    state_t       state, state_nx;
    logic [4:0]   cnt;
    logic         cache_valid;
    logic [127:0] st;
    logic [127:0] ka1, ka0;
    logic [127:0] rk [0:9];

    logic         hit;
    logic [5:0]   cidx;
    logic [127:0] c_const;
    logic [127:0] rk_sel;
    logic [127:0] lsx_in;
    logic [127:0] lsx_out;
    logic [127:0] feist;

    // K1/K2 are the master key halves, so they double as the cache tag.
    assign hit     = (CACHE_KEY != 0) && cache_valid && (key == {rk[0], rk[1]});
    assign cidx    = {1'b0, cnt} + 6'd1;
    assign c_const = lin_l({122'b0, cidx});
    assign lsx_in  = (state == ENC) ? (st ^ rk_sel) : (ka1 ^ c_const);
    assign lsx_out = lin_l(sub_s(lsx_in));
    assign feist   = lsx_out ^ ka0;

    always_comb begin
        rk_sel = '0;
        for (int i = 0; i < 10; i++) begin
            if (cnt == 5'(i)) rk_sel = rk[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)        state_nx = hit ? ENC : KEYEXP;
            KEYEXP:  if (cnt == 5'd31)    state_nx = ENC;
            ENC:     if (cnt == 5'd9)     state_nx = DONE;
            DONE:    if (out_ready)       state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= '0;
            encoded     <= '0;
            cnt         <= '0;
            cache_valid <= 1'b0;
            ka1         <= '0;
            ka0         <= '0;
            for (int i = 0; i < 10; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st  <= block;
                        cnt <= '0;
                        if (!hit) begin
                            ka1         <= key[255:128];
                            ka0         <= key[127:0];
                            rk[0]       <= key[255:128];
                            rk[1]       <= key[127:0];
                            cache_valid <= 1'b0;
                        end
                    end
                end
                KEYEXP: begin
                    ka1 <= feist;
                    ka0 <= ka1;
                    // every 8th step yields the next round-key pair
                    if (cnt[2:0] == 3'd7) begin
                        for (int g = 0; g < 4; g++) begin
                            if (cnt[4:3] == 2'(g)) begin
                                rk[2*g+2] <= feist;
                                rk[2*g+3] <= ka1;
                            end
                        end
                    end
                    if (cnt == 5'd31) begin
                        cnt         <= '0;
                        cache_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ENC: begin
                    if (cnt == 5'd9) begin
                        st      <= st ^ rk[9];
                        encoded <= st ^ rk[9];
                        cnt     <= '0;
                    end else begin
                        st  <= lsx_out;
                        cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kuznechik_enc_iter.sv
// Bench for kuznechik_enc_iter: cached and uncached instances, scoreboard of
// expected ciphertext/latency, and an independent encrypt/decrypt reference model.
module tb_kuznechik_enc_iter;

    localparam logic [127:0] STD_BLK = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [255:0] STD_KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] STD_ENC = 128'h7f679d90bebc24305a468d42b9d4edcd;

    localparam logic [2047:0] PI_HEX = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    // coefficients listed for a15 first, down to a0
    localparam logic [127:0] COEF_HEX = 128'h94208510c2c001fb01c0c2108520_9401;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_block, a_encoded;
    logic [255:0] a_key;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [127:0] b_block, b_encoded;
    logic [255:0] b_key;

    kuznechik_enc_iter #(.CACHE_KEY(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .block(a_block),
        .key(a_key), .encoded(a_encoded), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    kuznechik_enc_iter #(.CACHE_KEY(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .block(b_block),
        .key(b_key), .encoded(b_encoded), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [127:0] a_exp_q[$];
    logic [127:0] b_exp_q[$];
    int a_lat_q[$], b_lat_q[$], a_acc_q[$], b_acc_q[$];
    logic [7:0] pi_t [0:255];
    logic [7:0] pi_inv [0:255];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h1C3 << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_lin(input logic [127:0] v);
        logic [7:0] s;
        logic [127:0] cf;
        cf = COEF_HEX;
        s = '0;
        for (int j = 0; j < 16; j++) s = s ^ m_gmul(v[8*j +: 8], cf[127 - 8*(15-j) -: 8]);
        return s;
    endfunction

    function automatic logic [127:0] m_l(input logic [127:0] v);
        for (int r = 0; r < 16; r++) v = {m_lin(v), v[127:8]};
        return v;
    endfunction

    function automatic logic [127:0] m_linv(input logic [127:0] v);
        for (int r = 0; r < 16; r++) v = {v[119:0], m_lin({v[119:0], v[127:120]})};
        return v;
    endfunction

    function automatic logic [127:0] m_s(input logic [127:0] v, input bit inv);
        for (int j = 0; j < 16; j++) v[8*j +: 8] = inv ? pi_inv[v[8*j +: 8]] : pi_t[v[8*j +: 8]];
        return v;
    endfunction

    function automatic logic [1279:0] m_expand(input logic [255:0] k);
        logic [1279:0] ks;
        logic [127:0] a1, a0, t;
        a1 = k[255:128];
        a0 = k[127:0];
        ks = '0;
        ks[127:0] = a1;
        ks[255:128] = a0;
        for (int i = 1; i <= 32; i++) begin
            t = m_l(m_s(a1 ^ m_l(128'(i)), 1'b0)) ^ a0;
            a0 = a1;
            a1 = t;
            if (i % 8 == 0) begin
                ks[128*(i/4) +: 128] = a1;
                ks[128*(i/4+1) +: 128] = a0;
            end
        end
        return ks;
    endfunction

    function automatic logic [127:0] m_enc(input logic [127:0] b, input logic [255:0] k);
        logic [1279:0] ks;
        ks = m_expand(k);
        for (int r = 0; r < 9; r++) b = m_l(m_s(b ^ ks[128*r +: 128], 1'b0));
        return b ^ ks[128*9 +: 128];
    endfunction

    function automatic logic [127:0] m_dec(input logic [127:0] c, input logic [255:0] k);
        logic [1279:0] ks;
        ks = m_expand(k);
        c = c ^ ks[128*9 +: 128];
        for (int r = 8; r >= 0; r--) c = m_s(m_linv(c), 1'b1) ^ ks[128*r +: 128];
        return c;
    endfunction

    // ---------------- output monitors ----------------
    bit a_seen, b_seen;
    logic [127:0] a_hold, a_last, b_hold;

    always @(negedge clk) begin
        if (rst) a_seen = 1'b0;
        else if (a_out_valid) begin
            if (!a_seen) begin
                a_seen = 1'b1;
                a_hold = a_encoded;
                if (a_exp_q.size() == 0) check("a_unexpected_output", 1, 0);
                else begin
                    check("a_latency", 128'(edge_cnt - a_acc_q.pop_front()), 128'(a_lat_q.pop_front()));
                    check("a_encoded", a_encoded, a_exp_q.pop_front());
                    a_last = a_encoded;
                end
            end else check("a_encoded_stable", a_encoded, a_hold);
            if (a_out_ready) a_seen = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) b_seen = 1'b0;
        else if (b_out_valid) begin
            if (!b_seen) begin
                b_seen = 1'b1;
                b_hold = b_encoded;
                if (b_exp_q.size() == 0) check("b_unexpected_output", 1, 0);
                else begin
                    check("b_latency", 128'(edge_cnt - b_acc_q.pop_front()), 128'(b_lat_q.pop_front()));
                    check("b_encoded", b_encoded, b_exp_q.pop_front());
                end
            end else check("b_encoded_stable", b_encoded, b_hold);
            if (b_out_ready) b_seen = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input bit sel, input logic [127:0] blk, input logic [255:0] k,
                        input logic [127:0] exp, input int lat);
        int n;
        n = 0;
        @(posedge clk); #1;
        if (!sel) begin a_block = blk; a_key = k; a_in_valid = 1'b1; end
        else      begin b_block = blk; b_key = k; b_in_valid = 1'b1; end
        while (!(sel ? b_in_ready : a_in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("accept_timeout", 0, 1);
        else if (!sel) begin
            a_acc_q.push_back(edge_cnt + 1); a_exp_q.push_back(exp); a_lat_q.push_back(lat);
        end else begin
            b_acc_q.push_back(edge_cnt + 1); b_exp_q.push_back(exp); b_lat_q.push_back(lat);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        // inputs are meaningless after the accept edge
        a_block = rnd128(); a_key = {rnd128(), rnd128()};
        b_block = rnd128(); b_key = {rnd128(), rnd128()};
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        while ((sel ? (b_exp_q.size() != 0 || b_out_valid) : (a_exp_q.size() != 0 || a_out_valid)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] cur_key, k;
        logic [127:0] blk, tmp;
        int n, acc;

        tmp = '0;
        for (int i = 0; i < 256; i++) begin
            pi_t[i] = PI_HEX[2047 - 8*i -: 8];
            pi_inv[PI_HEX[2047 - 8*i -: 8]] = 8'(i);
        end

        rst = 1'b1;
        a_in_valid = 1'b0; a_block = '0; a_key = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_block = '0; b_key = '0; b_out_ready = 1'b1;
        #1;
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_encoded", a_encoded, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_encoded", b_encoded, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // standard vector, then cache hit and round trip
        send(0, STD_BLK, STD_KEY, STD_ENC, 42);
        drain(0);
        send(0, '0, STD_KEY, m_enc('0, STD_KEY), 10);
        drain(0);
        check("roundtrip_zero", m_dec(a_last, STD_KEY), 0);
        cur_key = {STD_KEY[127:0], STD_KEY[255:128]};
        send(0, STD_BLK, cur_key, m_enc(STD_BLK, cur_key), 42);
        drain(0);

        // alternating new/repeated keys with random blocks
        for (int t = 0; t < 4; t++) begin
            blk = rnd128();
            k = (t % 2 == 1) ? cur_key : {rnd128(), rnd128()};
            send(0, blk, k, m_enc(blk, k), (k == cur_key) ? 10 : 42);
            cur_key = k;
            drain(0);
        end

        // backpressure
        a_out_ready = 1'b0;
        blk = rnd128();
        send(0, blk, cur_key, m_enc(blk, cur_key), 10);
        n = 0;
        while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("bp_out_valid_timeout", 0, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", a_in_ready, 0);
            a_in_valid = (c >= 3 && c < 9);
            a_block = rnd128();
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_in_ready_before_release", a_in_ready, 0);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_out_valid_cleared", a_out_valid, 0);
        check("bp_in_ready_after", a_in_ready, 1);
        check("bp_no_extra_accept", 128'(a_exp_q.size()), 0);

        // async reset part way through key expansion
        send(0, STD_BLK, STD_KEY, STD_ENC, 42);
        acc = a_acc_q[a_acc_q.size() - 1];
        while (edge_cnt < acc + 17) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", a_in_ready, 1);
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_encoded", a_encoded, 0);
        a_exp_q.delete(); a_lat_q.delete(); a_acc_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(0, STD_BLK, STD_KEY, STD_ENC, 42);
        drain(0);
        send(0, STD_BLK, STD_KEY, STD_ENC, 10);
        drain(0);

        // uncached build: identical back-to-back requests both expand
        send(1, STD_BLK, STD_KEY, STD_ENC, 42);
        send(1, STD_BLK, STD_KEY, STD_ENC, 42);
        drain(1);
        check("b_queue_empty", 128'(b_exp_q.size()) | tmp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
